idwt97_lifting_unit_1d: RTL



---
 rtl/idwt97_lifting_unit_1d.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/idwt97_lifting_unit_1d.sv
// idwt97_lifting_unit_1d
//   Inverse 9/7 lifting pair for the row direction. Each accepted {high, low}
//   pair first has its update step undone (e[n] = l[n] - IB*(h[n-1]+h[n])),
//   then its predict step undone (o[n] = h[n] - IA*(e[n]+e[n+1])). The unit
//   emits reconstructed {odd, even} pairs. Line edges use symmetric extension:
//   h[-1] = h[0] and e[N] = e[N-1].
//
//   Pipeline: input register -> e register -> pending (h, e) pair -> output
//   register. Output pair n leaves when pair n+1 reaches the pending stage.
//   The last pair of a line leaves through a one-cycle DRAIN state.
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   s_valid_i/s_ready_o  input handshake
//   s_sof_i, s_eol_i     first / last pair of a line
//   s_data_i             {high, low}, signed DataWidth each
//   m_valid_o/m_ready_i  output handshake
//   m_sof_o, m_eol_o     first / last output pair of the line
//   m_data_o             {odd, even}, signed DataWidth each
module idwt97_lifting_unit_1d #(
  parameter int  DataWidth       = 16,
  parameter int  Point           = 10,
  // CDF 9/7 lifting constants
  parameter real Alpha           = -1.586134342059924,
  parameter real Beta            = -0.052980118572961,
  parameter int  MaximumSideSize = 512
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  output logic                   s_ready_o,
  input  logic                   s_valid_i,
  input  logic                   s_sof_i,
  input  logic                   s_eol_i,
  input  logic [2*DataWidth-1:0] s_data_i,
  input  logic                   m_ready_i,
  output logic                   m_valid_o,
  output logic                   m_sof_o,
  output logic                   m_eol_o,
  output logic [2*DataWidth-1:0] m_data_o
);

  localparam int W    = DataWidth;
  localparam int PW   = W + 33;  // (W+1)-bit sum times 32-bit coefficient
  localparam int CntW = (MaximumSideSize > 1) ? $clog2(MaximumSideSize) : 1;
  localparam int IA   = int'(Alpha * real'(1 << Point));
  localparam int IB   = int'(Beta * real'(1 << Point));

  typedef logic signed [W-1:0] sample_t;
  typedef enum logic [1:0] {FIRST, RUN, DRAIN} state_t;

  // base - floor(coef * (a + b) / 2^Point), everything wrapping at W bits.
  function automatic sample_t lift(input sample_t base, input sample_t a,
                                   input sample_t b, input int coef);
    logic signed [W:0]    sum;
    logic signed [PW-1:0] prod;
    sum  = {a[W-1], a} + {b[W-1], b};
    prod = PW'(sum) * PW'(coef);
    prod = prod >>> Point;
    return base - prod[W-1:0];
  endfunction

  // Input register
  logic    v1, sof1, eol1;
  sample_t h1, l1;
  // Extension tracking for the e computation
  logic    first_q;
  sample_t h_last;
  // e register
  logic    v2, sof2, eol2;
  sample_t h2, e2;
  // Pending pair (valid whenever state is RUN or DRAIN)
  sample_t ph, pe;
  logic [CntW-1:0] line_cnt;  // index of the next output pair in the line
  // Output register
  logic            v3, sof3, eol3;
  logic [2*W-1:0]  d3;

  state_t state, state_d;
  logic   live;  // low during reset, so s_ready_o stays low until release

  logic    out_free, start2, emit2, adv2, drain_emit, load3;
  logic    s2_free, adv1, s1_free, acc;
  sample_t hp, e_new, o_run, o_drain;

  assign out_free   = !v3 || m_ready_i;
  assign start2     = v2 && (state == FIRST || sof2);
  assign emit2      = v2 && state == RUN && !sof2;
  assign adv2       = v2 && state != DRAIN && (!emit2 || out_free);
  assign drain_emit = state == DRAIN && out_free;
  assign load3      = (adv2 && emit2) || drain_emit;
  assign s2_free    = !v2 || adv2;
  assign adv1       = v1 && s2_free;
  assign s1_free    = !v1 || adv1;
  assign s_ready_o  = live && state != DRAIN && s1_free;
  assign acc        = s_valid_i && s_ready_o;

  assign hp      = (sof1 || first_q) ? h1 : h_last;
  assign e_new   = lift(l1, hp, h1, IB);
  assign o_run   = lift(ph, pe, e2, IA);
  assign o_drain = lift(ph, pe, pe, IA);

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state;
    if (state == DRAIN) begin
      if (out_free) state_d = FIRST;
    end else if (adv2) begin
      state_d = eol2 ? DRAIN : RUN;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= FIRST;
      live  <= 1'b0;
    end else begin
      state <= state_d;
      live  <= 1'b1;
    end
  end

  // NOTE: the data registers are reset as well, so no value from an aborted
  // line can reach the output after reset is released.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v1      <= 1'b0;
      sof1    <= 1'b0;
      eol1    <= 1'b0;
      h1      <= '0;
      l1      <= '0;
      first_q <= 1'b1;
      h_last  <= '0;
    end else begin
      if (s1_free) begin
        v1 <= acc;
        if (acc) begin
          h1   <= s_data_i[2*W-1:W];
          l1   <= s_data_i[W-1:0];
          sof1 <= s_sof_i;
          eol1 <= s_eol_i;
        end
      end
      if (adv1) begin
        h_last  <= h1;
        first_q <= eol1;  // the pair after an eol starts a line
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v2   <= 1'b0;
      sof2 <= 1'b0;
      eol2 <= 1'b0;
      h2   <= '0;
      e2   <= '0;
    end else if (s2_free) begin
      v2 <= adv1;
      if (adv1) begin
        h2   <= h1;
        e2   <= e_new;
        sof2 <= sof1;
        eol2 <= eol1;
      end
    end
  end

  // A line start (FIRST, or sof while RUN) overwrites the pending pair
  // without emitting it; that is how an interrupted line is discarded.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ph       <= '0;
      pe       <= '0;
      line_cnt <= '0;
    end else begin
      if (adv2) begin
        ph <= h2;
        pe <= e2;
      end
      if (adv2 && start2) begin
        line_cnt <= '0;
      end else if (load3) begin
        line_cnt <= (line_cnt == CntW'(MaximumSideSize - 1)) ? '0
                                                             : line_cnt + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v3   <= 1'b0;
      sof3 <= 1'b0;
      eol3 <= 1'b0;
      d3   <= '0;
    end else if (load3) begin
      v3   <= 1'b1;
      sof3 <= line_cnt == '0;
      eol3 <= drain_emit;
      d3   <= {drain_emit ? o_drain : o_run, pe};
    end else if (m_ready_i) begin
      v3 <= 1'b0;
    end
  end

  assign m_valid_o = v3;
  assign m_sof_o   = sof3;
  assign m_eol_o   = eol3;
  assign m_data_o  = d3;

endmodule
